// File: rtl/rx_frame_checker.sv
// UART receive-frame checker: serial data assembly, four-mode parity check,
// one/two stop-bit check and a saturating frame-error counter.
module rx_frame_checker #(
   parameter int Data_width = 8,
   parameter int Cnt_width  = 8
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              frame_start,
   input  logic                              bit_valid,
   input  logic                              sampled_bit,
   input  logic [$clog2(Data_width+1)-1:0]   DATA_LEN,
   input  logic                              PAR_EN,
   input  logic [1:0]                        PAR_MODE,
   input  logic                              STOP_2,
   input  logic                              err_clr,
   output logic [Data_width-1:0]             P_DATA,
   output logic                              data_valid,
   output logic                              par_err,
   output logic                              stp_err,
   output logic [Cnt_width-1:0]              err_cnt,
   output logic                              busy
);

   localparam int LW = $clog2(Data_width + 1);

   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, REPORT} state_t;

   state_t                state;
   logic [Data_width-1:0] shift;
   logic [LW-1:0]         bit_cnt;
   logic [LW-1:0]         len_m1;
   logic [LW-1:0]         len_m1_nxt;
   logic                  par_run;
   logic                  par_flag;
   logic                  stp_flag;
   logic                  stop_cnt;
   logic                  pen_q;
   logic [1:0]            mode_q;
   logic                  s2_q;
   logic                  exp_par;
   logic                  stp_final;

   // Frame length is clamped to 5..Data_width and held as (len - 1).
   always_comb begin
      if (DATA_LEN < LW'(5))
         len_m1_nxt = LW'(4);
      else if (DATA_LEN > LW'(Data_width))
         len_m1_nxt = LW'(Data_width - 1);
      else
         len_m1_nxt = DATA_LEN - LW'(1);
   end

   always_comb begin
      exp_par = 1'b0;
      case (mode_q)
         2'b00:   exp_par = par_run;
         2'b01:   exp_par = ~par_run;
         2'b10:   exp_par = 1'b1;
         default: exp_par = 1'b0;
      endcase
   end

   assign stp_final = stp_flag | ~sampled_bit;
   assign busy      = (state != IDLE);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state      <= IDLE;
         shift      <= '0;
         bit_cnt    <= '0;
         len_m1     <= '0;
         par_run    <= 1'b0;
         par_flag   <= 1'b0;
         stp_flag   <= 1'b0;
         stop_cnt   <= 1'b0;
         pen_q      <= 1'b0;
         mode_q     <= '0;
         s2_q       <= 1'b0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         err_cnt    <= '0;
      end else begin
         data_valid <= 1'b0;
         if (err_clr)
            err_cnt <= '0;

         // frame_start restarts from any state; a REPORT in progress has
         // already loaded its outputs on entry, so it still completes.
         if (frame_start) begin
            state    <= DATA;
            shift    <= '0;
            bit_cnt  <= '0;
            par_run  <= 1'b0;
            par_flag <= 1'b0;
            stp_flag <= 1'b0;
            stop_cnt <= 1'b0;
            len_m1   <= len_m1_nxt;
            pen_q    <= PAR_EN;
            mode_q   <= PAR_MODE;
            s2_q     <= STOP_2;
         end else begin
            case (state)
               DATA: if (bit_valid) begin
                  shift   <= shift | (Data_width'(sampled_bit) << bit_cnt);
                  par_run <= par_run ^ sampled_bit;
                  bit_cnt <= bit_cnt + LW'(1);
                  if (bit_cnt == len_m1)
                     state <= pen_q ? PARITY : STOP;
               end
               PARITY: if (bit_valid) begin
                  par_flag <= sampled_bit ^ exp_par;
                  state    <= STOP;
               end
               STOP: if (bit_valid) begin
                  if (!s2_q || stop_cnt) begin
                     state      <= REPORT;
                     data_valid <= 1'b1;
                     P_DATA     <= shift;
                     par_err    <= par_flag;
                     stp_err    <= stp_final;
                     if (!err_clr && (par_flag || stp_final) && (err_cnt != '1))
                        err_cnt <= err_cnt + Cnt_width'(1);
                  end else begin
                     stp_flag <= stp_final;
                     stop_cnt <= 1'b1;
                  end
               end
               REPORT:  state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed bench for rx_frame_checker (2-bit error counter to reach saturation).
module tb_rx_frame_checker;

   logic       CLK = 1'b0;
   logic       RST;
   logic       frame_start;
   logic       bit_valid;
   logic       sampled_bit;
   logic [3:0] DATA_LEN;
   logic       PAR_EN;
   logic [1:0] PAR_MODE;
   logic       STOP_2;
   logic       err_clr;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;
   logic [1:0] err_cnt;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int dv_cnt = 0;
   int dv_base;

   rx_frame_checker #(.Data_width(8), .Cnt_width(2)) dut (
      .CLK(CLK), .RST(RST), .frame_start(frame_start), .bit_valid(bit_valid),
      .sampled_bit(sampled_bit), .DATA_LEN(DATA_LEN), .PAR_EN(PAR_EN),
      .PAR_MODE(PAR_MODE), .STOP_2(STOP_2), .err_clr(err_clr),
      .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
      .stp_err(stp_err), .err_cnt(err_cnt), .busy(busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (data_valid === 1'b1) dv_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [3:0] len, input logic pen, input logic [1:0] mode,
                        input logic s2);
      frame_start = 1'b1;
      DATA_LEN    = len;
      PAR_EN      = pen;
      PAR_MODE    = mode;
      STOP_2      = s2;
      tick();
      frame_start = 1'b0;
      DATA_LEN    = 4'd8;
      PAR_EN      = ~pen;
      PAR_MODE    = ~mode;
      STOP_2      = ~s2;
   endtask

   task automatic send_bit(input logic b);
      bit_valid   = 1'b1;
      sampled_bit = b;
      tick();
      bit_valid   = 1'b0;
   endtask

   task automatic body(input int nbits, input logic pen, input logic s2, input logic [7:0] d,
                       input logic pb, input logic sb1, input logic sb2);
      for (int i = 0; i < nbits; i++) begin
         send_bit(d[i]);
         tick();
      end
      if (pen) send_bit(pb);
      if (s2) begin
         send_bit(sb1);
         tick();
         send_bit(sb2);
      end else begin
         send_bit(sb1);
      end
   endtask

   task automatic report(input string tag, input logic [7:0] d, input logic pe,
                         input logic se, input logic [1:0] cnt);
      chk({tag, " data_valid"}, 32'(data_valid), 32'd1);
      chk({tag, " P_DATA"},     32'(P_DATA),     32'(d));
      chk({tag, " par_err"},    32'(par_err),    32'(pe));
      chk({tag, " stp_err"},    32'(stp_err),    32'(se));
      chk({tag, " err_cnt"},    32'(err_cnt),    32'(cnt));
      tick();
      chk({tag, " dv_drop"},    32'(data_valid), 32'd0);
   endtask

   initial begin
      RST = 1'b0; frame_start = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
      DATA_LEN = 4'd8; PAR_EN = 1'b0; PAR_MODE = 2'b00; STOP_2 = 1'b0; err_clr = 1'b0;
      tick(); tick();
      chk("rst P_DATA", 32'(P_DATA), 32'd0);
      chk("rst data_valid", 32'(data_valid), 32'd0);
      chk("rst par_err", 32'(par_err), 32'd0);
      chk("rst stp_err", 32'(stp_err), 32'd0);
      chk("rst err_cnt", 32'(err_cnt), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      RST = 1'b1;
      tick();

      // bit_valid while idle is ignored
      send_bit(1'b1);
      chk("idle busy", 32'(busy), 32'd0);

      start(4'd8, 1'b1, 2'b00, 1'b0);
      chk("frame busy", 32'(busy), 32'd1);
      body(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
      chk("report busy", 32'(busy), 32'd1);
      report("even_ok", 8'hA5, 1'b0, 1'b0, 2'd0);
      chk("after busy", 32'(busy), 32'd0);

      start(4'd8, 1'b1, 2'b00, 1'b0);
      body(8, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1);
      report("even_bad", 8'hA5, 1'b1, 1'b0, 2'd1);

      start(4'd8, 1'b1, 2'b01, 1'b0);
      body(8, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1);
      report("odd_ok", 8'hA5, 1'b0, 1'b0, 2'd1);

      start(4'd5, 1'b0, 2'b00, 1'b1);
      body(5, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 1'b0);
      report("len5_stop2", 8'h13, 1'b0, 1'b1, 2'd2);

      start(4'd3, 1'b0, 2'b00, 1'b0);
      body(5, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b1, 1'b1);
      report("len3_as5", 8'h0A, 1'b0, 1'b0, 2'd2);

      start(4'd8, 1'b1, 2'b10, 1'b0);
      body(8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      report("mark_bad", 8'h00, 1'b1, 1'b0, 2'd3);

      start(4'd8, 1'b1, 2'b11, 1'b0);
      body(8, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
      report("space_ok", 8'hFF, 1'b0, 1'b0, 2'd3);

      start(4'd8, 1'b1, 2'b10, 1'b0);
      body(8, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
      report("mark_sat", 8'hFF, 1'b1, 1'b0, 2'd3);

      start(4'd8, 1'b1, 2'b00, 1'b0);
      body(8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      report("stop_sat", 8'h00, 1'b0, 1'b1, 2'd3);

      // abort after four data bits, then a clean frame
      dv_base = dv_cnt;
      start(4'd8, 1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      start(4'd8, 1'b1, 2'b00, 1'b0);
      chk("abort P_DATA held", 32'(P_DATA), 32'h00);
      body(8, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1);
      report("abort_clean", 8'h3C, 1'b0, 1'b0, 2'd3);
      chk("abort dv count", 32'(dv_cnt - dv_base), 32'd1);

      // frame_start in the REPORT cycle
      start(4'd8, 1'b1, 2'b00, 1'b0);
      body(8, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1);
      chk("rep_start dv", 32'(data_valid), 32'd1);
      chk("rep_start P_DATA", 32'(P_DATA), 32'h81);
      start(4'd8, 1'b1, 2'b00, 1'b0);
      chk("rep_start busy", 32'(busy), 32'd1);
      chk("rep_start dv drop", 32'(data_valid), 32'd0);
      body(8, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
      report("after_rep_start", 8'h5A, 1'b0, 1'b0, 2'd3);

      // err_clr together with the sixth error frame's final stop bit
      start(4'd8, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(1'b0);
      err_clr = 1'b1;
      send_bit(1'b0);
      err_clr = 1'b0;
      report("clr_wins", 8'h00, 1'b0, 1'b1, 2'd0);

      // reset mid-frame
      start(4'd8, 1'b1, 2'b00, 1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      RST = 1'b0;
      tick();
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst stp_err", 32'(stp_err), 32'd0);
      chk("midrst dv", 32'(data_valid), 32'd0);
      RST = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rx_frame_checker.md
Name: rx_frame_checker

Overview:
Sequential UART receive-frame checker and the successor to the combinational parity checker. It accumulates data bits serially as they are sampled and checks parity in one of four parity modes. It also checks one or two stop bits and reports the assembled word with error flags. It sits between the RX edge/bit sampler and the RX FSM output stage, and keeps a saturating error counter for status readout.

Parameters:
Data_width, 8, maximum data bits per frame; P_DATA width
Cnt_width, 8, width of the saturating frame-error counter

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous active-low reset
frame_start  input  1  one-cycle pulse when a valid start bit is detected
bit_valid  input  1  one-cycle pulse; sampled_bit is valid (mid-bit sample)
sampled_bit  input  1  sampled serial bit value
DATA_LEN  input  $clog2(Data_width+1)  data bits per frame; latched at frame_start
PAR_EN  input  1  1 = parity bit present; latched at frame_start
PAR_MODE  input  2  00 even, 01 odd, 10 mark (1), 11 space (0); latched at frame_start
STOP_2  input  1  1 = two stop bits, 0 = one; latched at frame_start
err_clr  input  1  clears err_cnt
P_DATA  output  Data_width  received word, LSB first on the line; unused MSBs zero
data_valid  output  1  one-cycle pulse when a frame completes
par_err  output  1  parity error of the last completed frame
stp_err  output  1  stop error of the last completed frame
err_cnt  output  Cnt_width  saturating count of frames with par_err or stp_err
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (RST=0 at a CLK edge) sets these values:
  - all outputs 0;
  - state IDLE;
  - internal shift register, bit counter and running parity 0.
- State IDLE: frame_start -> DATA. On entry, clear the shift register, bit_cnt and running parity, and latch DATA_LEN, PAR_EN, PAR_MODE and STOP_2.
- Effective length is DATA_LEN clamped to the range 5..Data_width (below 5 uses 5; above Data_width uses Data_width).
- State DATA, on each bit_valid:
  - write sampled_bit to shift[bit_cnt];
  - running parity ^= sampled_bit;
  - bit_cnt++.
  - On the bit with bit_cnt == len-1, go to PARITY if PAR_EN, else STOP.
- State PARITY, on bit_valid:
  - expected bit = running (even), ~running (odd), 1 (mark), 0 (space);
  - internal parity flag = sampled_bit ^ expected;
  - go to STOP.
- If PAR_EN=0, the parity flag is 0.
- State STOP, on each bit_valid:
  - sampled_bit==0 sets the internal stop flag (sticky within the frame);
  - after 1 stop bit (STOP_2=0) or 2 (STOP_2=1), go to REPORT.
- State REPORT (exactly one cycle):
  - data_valid=1;
  - P_DATA, par_err and stp_err load from the internal values and hold until the next REPORT;
  - err_cnt +1 if either flag is set, saturating at all-ones;
  - then go to IDLE.
- Latency: data_valid is high in the cycle after the CLK edge that samples the bit_valid of the final stop bit.
- bit_valid in IDLE or REPORT is ignored.
- frame_start in DATA, PARITY or STOP aborts the current frame:
  - it re-initialises as on IDLE->DATA entry;
  - no data_valid, outputs unchanged, no count.
- frame_start in REPORT: the report completes normally, then the state goes directly to DATA with fresh init and latch.
- frame_start and bit_valid in the same cycle: frame_start wins; that bit_valid is dropped.
- err_clr zeroes err_cnt next edge; err_clr with a simultaneous increment: clear wins.
- Config inputs changing mid-frame have no effect on the frame in progress.
- RST=0 mid-frame: immediate return to the reset state on that edge; no report.

Test Plan:
- Config 8 bits, even parity, 1 stop. Line bits 0xA5 LSB-first, parity bit 0, stop 1 -> one data_valid pulse, P_DATA=0xA5, par_err=0, stp_err=0, err_cnt=0.
- Same frame with parity bit 1 -> par_err=1, err_cnt=1. Then an odd-parity frame 0xA5 with parity bit 1 -> par_err=0, err_cnt stays 1.
- DATA_LEN=5, PAR_EN=0, STOP_2=1, data 0x13, stops 1 then 0 -> P_DATA=0x13 (bits 7:5 zero), stp_err=1. DATA_LEN=3 behaves as 5.
- Mark mode, parity bit 0 -> par_err=1. Space mode, parity bit 0 -> par_err=0. Both hold regardless of data.
- frame_start after 4 data bits, then a clean 0x3C frame -> only one data_valid, P_DATA=0x3C. Also frame_start in the REPORT cycle -> the report occurs and the next frame is received correctly.
- With Cnt_width=2, send 5 error frames -> err_cnt saturates at 3. err_clr coinciding with a 6th error REPORT -> err_cnt=0.
